lcd_text_writer: RTL and testbench

- Downstream consumer of the 64-byte constant text memory (4 lines x 16 chars, 6-bit address, 1-cycle registered read).
- Initialises an HD44780-compatible 16x4 character LCD in 4-bit mode, then on request sweeps all 64 memory addresses and writes each character to the correct LCD position.
- Sits between the text memory and the board LCD pins.

---
 rtl/lcd_pkg.sv | 61 ++++++
 rtl/lcd_nibble_tx.sv | 122 ++++++++++++
 rtl/lcd_text_writer.sv | 205 ++++++++++++++++++++
 tb/tb_lcd_text_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text writer: FSM encodings, HD44780
// command bytes and default timing values.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT3A,
    ST_INIT3B,
    ST_INIT3C,
    ST_INIT2,
    ST_CFG,
    ST_IDLE,
    ST_LADDR,
    ST_FETCH,
    ST_WCHAR,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_EHIGH,
    TX_GAP,
    TX_WAIT
  } tx_state_t;

  // Command bytes
  localparam logic [7:0] FUNC_SET_4B  = 8'h28;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] SET_DDRAM    = 8'h80;
  // Init nibbles travel in the high half of the byte
  localparam logic [7:0] INIT_8BIT    = 8'h30;
  localparam logic [7:0] INIT_4BIT    = 8'h20;

  // Default timing in clock cycles at 50 MHz
  localparam int DEF_T_PWRUP = 750000;
  localparam int DEF_T_EH    = 12;
  localparam int DEF_T_NGAP  = 50;
  localparam int DEF_T_CMD   = 2000;
  localparam int DEF_T_CLR   = 82000;

  // DDRAM base per line, line 3..0 packed
  localparam logic [31:0] DEF_LINE_BASE = {8'h50, 8'h10, 8'h40, 8'h00};

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Configuration byte sequence sent after the 4-bit switch
  function automatic logic [7:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET_4B;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one byte (or one high nibble) to the LCD over the 4-bit bus:
// setup cycle, E pulse, inter-nibble gap, then a post-byte wait during
// which oReady stays low.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int T_EH   = DEF_T_EH,
  parameter int T_NGAP = DEF_T_NGAP,
  parameter int CNT_W  = 20
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [7:0]       ivByte,
  input  logic             iRs,
  input  logic             iSingleNibble,
  input  logic [CNT_W-1:0] ivPostWait,
  output logic             oReady,
  output logic [3:0]       ovLcdData,
  output logic             oLcdRs,
  output logic             oLcdE
);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [3:0]       data_q, data_d;
  logic [3:0]       low_q, low_d;
  logic             rs_q, rs_d;
  logic             second_q, second_d;
  logic             e_q, e_d;

  // Next-state: walks setup -> E high -> gap (twice for a full byte) -> wait
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    data_d   = data_q;
    low_d    = low_q;
    rs_d     = rs_q;
    second_d = second_q;
    case (state_q)
      TX_IDLE: begin
        if (iStart) begin
          data_d   = ivByte[7:4];
          low_d    = ivByte[3:0];
          rs_d     = iRs;
          second_d = ~iSingleNibble;
          wait_d   = ivPostWait;
          cnt_d    = '0;
          state_d  = TX_SETUP;
        end
      end
      TX_SETUP: begin
        cnt_d   = '0;
        state_d = TX_EHIGH;
      end
      TX_EHIGH: begin
        if (cnt_q == CNT_W'(T_EH - 1)) begin
          cnt_d   = '0;
          state_d = TX_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_GAP: begin
        if (cnt_q == CNT_W'(T_NGAP - 1)) begin
          cnt_d = '0;
          if (second_q) begin
            // Low nibble goes out after its own setup cycle
            data_d   = low_q;
            second_d = 1'b0;
            state_d  = TX_SETUP;
          end else begin
            state_d = TX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_WAIT: begin
        if ((wait_q == '0) || (cnt_q == wait_q - 1'b1)) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    e_d = (state_d == TX_EHIGH);
  end

  // State and bus registers; E is registered so it cannot glitch
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      low_q    <= '0;
      rs_q     <= 1'b0;
      second_q <= 1'b0;
      e_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      low_q    <= low_d;
      rs_q     <= rs_d;
      second_q <= second_d;
      e_q      <= e_d;
    end
  end

  assign oReady    = (state_q == TX_IDLE);
  assign ovLcdData = data_q;
  assign oLcdRs    = rs_q;
  assign oLcdE     = e_q;

endmodule

// File: rtl/lcd_text_writer.sv
// Initialises a 16x4 HD44780 LCD in 4-bit mode, then on request copies the
// 64-byte text memory to the display, one line-address command per line.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int          T_PWRUP   = DEF_T_PWRUP,
  parameter int          T_EH      = DEF_T_EH,
  parameter int          T_NGAP    = DEF_T_NGAP,
  parameter int          T_CMD     = DEF_T_CMD,
  parameter int          T_CLR     = DEF_T_CLR,
  parameter logic [31:0] LINE_BASE = DEF_LINE_BASE
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  output logic [5:0] ovAddress,
  input  logic [7:0] ivData,
  output logic       oBusy,
  output logic       oDone,
  output logic [3:0] ovLcdData,
  output logic       oLcdRs,
  output logic       oLcdRw,
  output logic       oLcdE
);

  localparam int CNT_MAX = max_of(max_of(T_PWRUP, T_CLR),
                                  max_of(T_CMD, max_of(T_EH, T_NGAP)));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       line_q, line_d;
  logic [3:0]       col_q, col_d;
  logic [7:0]       char_q, char_d;
  logic [1:0]       cfg_q, cfg_d;
  logic             issued_q, issued_d;

  logic             is_send, send_done;
  logic             tx_start, tx_ready, tx_rs, tx_single;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] tx_wait;

  lcd_nibble_tx #(
    .T_EH   (T_EH),
    .T_NGAP (T_NGAP),
    .CNT_W  (CNT_W)
  ) u_tx (
    .iClk          (iClk),
    .iRst          (iRst),
    .iStart        (tx_start),
    .ivByte        (tx_byte),
    .iRs           (tx_rs),
    .iSingleNibble (tx_single),
    .ivPostWait    (tx_wait),
    .oReady        (tx_ready),
    .ovLcdData     (ovLcdData),
    .oLcdRs        (oLcdRs),
    .oLcdE         (oLcdE)
  );

  // Sequencer: picks the transfer for the current state, issues it once,
  // and advances when the transmitter reports the post-wait has expired
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    col_d     = col_q;
    char_d    = char_q;
    cfg_d     = cfg_q;
    issued_d  = issued_q;
    is_send   = 1'b0;
    tx_byte   = '0;
    tx_rs     = 1'b0;
    tx_single = 1'b0;
    tx_wait   = CNT_W'(T_CMD);

    case (state_q)
      ST_INIT3A, ST_INIT3B, ST_INIT3C: begin
        is_send   = 1'b1;
        tx_byte   = INIT_8BIT;
        tx_single = 1'b1;
      end
      ST_INIT2: begin
        is_send   = 1'b1;
        tx_byte   = INIT_4BIT;
        tx_single = 1'b1;
      end
      ST_CFG: begin
        is_send = 1'b1;
        tx_byte = cfg_cmd(cfg_q);
        if (cfg_q == 2'd3) tx_wait = CNT_W'(T_CLR);
      end
      ST_LADDR: begin
        is_send = 1'b1;
        tx_byte = SET_DDRAM | LINE_BASE[{line_q, 3'b000} +: 8];
      end
      ST_WCHAR: begin
        is_send = 1'b1;
        tx_byte = char_q;
        tx_rs   = 1'b1;
      end
      default: ;
    endcase

    // A transfer is requested once; tx_ready returning afterwards means done
    tx_start  = is_send && !issued_q && tx_ready;
    send_done = is_send && issued_q && tx_ready;
    if (tx_start)  issued_d = 1'b1;
    if (send_done) issued_d = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(T_PWRUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_INIT3A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT3A: if (send_done) state_d = ST_INIT3B;
      ST_INIT3B: if (send_done) state_d = ST_INIT3C;
      ST_INIT3C: if (send_done) state_d = ST_INIT2;
      ST_INIT2:  if (send_done) state_d = ST_CFG;
      ST_CFG: begin
        if (send_done) begin
          if (cfg_q == 2'd3) begin
            cfg_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cfg_d = cfg_q + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (iStart) begin
          line_d  = '0;
          col_d   = '0;
          state_d = ST_LADDR;
        end
      end
      ST_LADDR: begin
        if (send_done) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Address is already stable; data is captured on the second cycle
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          char_d  = ivData;
          state_d = ST_WCHAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WCHAR: begin
        if (send_done) begin
          if (col_q == 4'd15) begin
            if (line_q == 2'd3) begin
              state_d = ST_DONE;
            end else begin
              line_d  = line_q + 1'b1;
              col_d   = '0;
              state_d = ST_LADDR;
            end
          end else begin
            col_d   = col_q + 1'b1;
            cnt_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_PWRUP;
    endcase
  end

  // Sequencer registers; reset restarts the power-up wait
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_PWRUP;
      cnt_q    <= '0;
      line_q   <= '0;
      col_q    <= '0;
      char_q   <= '0;
      cfg_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      col_q    <= col_d;
      char_q   <= char_d;
      cfg_q    <= cfg_d;
      issued_q <= issued_d;
    end
  end

  assign ovAddress = {line_q, col_q};
  assign oBusy     = (state_q != ST_IDLE);
  assign oDone     = (state_q == ST_DONE);
  assign oLcdRw    = 1'b0;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with shortened LCD timing.
module tb_lcd_text_writer;

  localparam int T_PWRUP = 20;
  localparam int T_EH    = 2;
  localparam int T_NGAP  = 3;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;

  logic       iClk, iRst, iStart;
  logic [5:0] ovAddress;
  logic [7:0] ivData;
  logic       oBusy, oDone, oLcdRs, oLcdRw, oLcdE;
  logic [3:0] ovLcdData;

  lcd_text_writer #(
    .T_PWRUP (T_PWRUP),
    .T_EH    (T_EH),
    .T_NGAP  (T_NGAP),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .ovAddress (ovAddress),
    .ivData    (ivData),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .ovLcdData (ovLcdData),
    .oLcdRs    (oLcdRs),
    .oLcdRw    (oLcdRw),
    .oLcdE     (oLcdE)
  );

  int         errs, checks, cyc;
  logic [7:0] mem [64];
  logic [4:0] nq [$];
  int         tim_bad, last_fall_cyc, hi_cnt;
  logic       ignore_tim;
  logic       e_last, rs_last, rs_rise;
  logic [3:0] d_last, d_rise;

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge iClk);
      cyc++;
    end
  end

  // Text memory with a one-cycle registered read
  initial begin
    forever begin
      @(posedge iClk);
      ivData <= mem[ovAddress];
    end
  end

  // Bus monitor: records every nibble at E rise and checks E width and data hold
  initial begin
    e_last = 1'b0; rs_last = 1'b0; d_last = '0; d_rise = '0; rs_rise = 1'b0;
    hi_cnt = 0; tim_bad = 0; last_fall_cyc = 0;
    forever begin
      @(negedge iClk);
      if (oLcdE && !e_last) begin
        if (!ignore_tim && (ovLcdData !== d_last || oLcdRs !== rs_last)) tim_bad++;
        d_rise  = ovLcdData;
        rs_rise = oLcdRs;
        hi_cnt  = 1;
        nq.push_back({oLcdRs, ovLcdData});
      end else if (oLcdE) begin
        hi_cnt++;
        if (!ignore_tim && (ovLcdData !== d_rise || oLcdRs !== rs_rise)) tim_bad++;
      end else if (e_last) begin
        if (!ignore_tim && (hi_cnt != T_EH || ovLcdData !== d_rise || oLcdRs !== rs_rise))
          tim_bad++;
        last_fall_cyc = cyc;
      end
      e_last  = oLcdE;
      d_last  = ovLcdData;
      rs_last = oLcdRs;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge iClk);
      if (oBusy === level) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge iClk);
      if (oDone === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_init(input int base);
    logic [3:0] exp_n [12];
    exp_n = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    check("init_nibble_count", 32'(nq.size() - base), 32'd12);
    for (int k = 0; k < 12; k++)
      if (base + k < nq.size())
        check($sformatf("init_nibble%0d", k), 32'(nq[base + k]), 32'({1'b0, exp_n[k]}));
  endtask

  task automatic check_refresh(input string name, input int base);
    logic [7:0] laddr [4];
    logic [7:0] eb;
    logic       ers;
    int         idx;
    laddr = '{8'h80, 8'hC0, 8'h90, 8'hD0};
    check({name, "_e_pulses"}, 32'(nq.size() - base), 32'd136);
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 17; b++) begin
        idx = base + 2 * (l * 17 + b);
        if (b == 0) begin
          eb = laddr[l]; ers = 1'b0;
        end else begin
          eb = mem[l * 16 + b - 1]; ers = 1'b1;
        end
        if (idx + 1 < nq.size())
          check($sformatf("%s_l%0d_b%0d", name, l, b),
                32'({nq[idx][4], nq[idx + 1][4], nq[idx][3:0], nq[idx + 1][3:0]}),
                32'({ers, ers, eb}));
      end
    end
  endtask

  initial begin
    int   base, d, ehi;
    logic ok;
    errs = 0; checks = 0;
    ignore_tim = 1'b0;
    iRst = 1'b1; iStart = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'h30 + i);

    // Reset state
    repeat (3) @(negedge iClk);
    check("rst_busy",    32'(oBusy),     32'd1);
    check("rst_done",    32'(oDone),     32'd0);
    check("rst_e",       32'(oLcdE),     32'd0);
    check("rst_addr",    32'(ovAddress), 32'd0);
    check("rst_data",    32'(ovLcdData), 32'd0);
    check("rst_rs",      32'(oLcdRs),    32'd0);
    check("rst_rw",      32'(oLcdRw),    32'd0);

    // Power-up wait: E quiet for T_PWRUP cycles
    iRst = 1'b0;
    ehi = 0;
    repeat (T_PWRUP) begin
      @(negedge iClk);
      if (oLcdE) ehi++;
    end
    check("pwrup_e_quiet", 32'(ehi), 32'd0);
    check("pwrup_busy", 32'(oBusy), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge iClk);
      if (nq.size() > 0) ok = 1'b1;
    end
    check("first_e_seen", 32'(ok), 32'd1);
    if (ok) check("first_nibble", 32'(nq[0]), 32'h03);

    // Init sequence and Clear wait
    wait_busy(1'b0, 3000, ok);
    check("init_busy_drop", 32'(ok), 32'd1);
    d = cyc - last_fall_cyc;
    check("clr_wait_range", 32'((d >= T_NGAP + T_CLR) && (d <= T_NGAP + T_CLR + 3)), 32'd1);
    check_init(0);
    check("init_timing", 32'(tim_bad), 32'd0);

    // Refresh 1: single-cycle start pulse
    base = nq.size();
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    check("ref1_busy", 32'(oBusy), 32'd1);
    wait_done(5000, ok);
    check("ref1_done_seen", 32'(ok), 32'd1);
    check("ref1_addr_end", 32'(ovAddress), 32'd63);
    @(negedge iClk);
    check("ref1_done_pulse", 32'(oDone), 32'd0);
    check("ref1_idle", 32'(oBusy), 32'd0);
    check_refresh("ref1", base);
    check("ref1_timing", 32'(tim_bad), 32'd0);

    // Refresh 2: start held high for the whole refresh, new text
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;
    base = nq.size();
    @(negedge iClk); iStart = 1'b1;
    wait_done(5000, ok);
    iStart = 1'b0;
    check("ref2_done_seen", 32'(ok), 32'd1);
    repeat (40) @(negedge iClk);
    check("ref2_no_requeue", 32'(oBusy), 32'd0);
    check_refresh("ref2", base);
    check("ref2_timing", 32'(tim_bad), 32'd0);

    // Reset while line 2 col 7 is being written
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge iClk);
      if (ovAddress === 6'd39 && oLcdE === 1'b1 && oLcdRs === 1'b1) ok = 1'b1;
    end
    check("mid_write_seen", 32'(ok), 32'd1);
    ignore_tim = 1'b1;
    iRst = 1'b1;
    @(negedge iClk);
    check("abort_e",    32'(oLcdE),     32'd0);
    check("abort_addr", 32'(ovAddress), 32'd0);
    check("abort_busy", 32'(oBusy),     32'd1);
    iRst = 1'b0;
    base = nq.size();
    @(negedge iClk);
    ignore_tim = 1'b0;
    wait_busy(1'b0, 3000, ok);
    check("reinit_busy_drop", 32'(ok), 32'd1);
    check_init(base);

    // Refresh after recovery with a third text pattern
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'hC0 - 2 * i);
    base = nq.size();
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    wait_done(5000, ok);
    check("ref3_done_seen", 32'(ok), 32'd1);
    @(negedge iClk);
    check_refresh("ref3", base);
    check("final_timing", 32'(tim_bad), 32'd0);
    check("final_rw", 32'(oLcdRw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
